// File: rtl/sdcrtt_reg.sv
// rtl/sdcrtt_reg.sv - WIDTH-bit register with per-bit set/clear, complementary outputs and 8 operation modes
//
// Ports:
//   clk   - clock, all state updates on rising edge
//   nr    - synchronous active-low reset (overrides everything else)
//   en    - mode operation enable; when low the mode result is the current q
//   mode  - 000 hold, 001 load, 010 toggle, 011 shift left, 100 shift right,
//           101 rotate left, 110 count up, 111 count down
//   d     - parallel load data / toggle mask
//   s, r  - per-bit synchronous set / clear, applied after the mode result
//   sin   - serial input for the shift modes
//   q     - register value
//   nq    - registered complement of q
//   sout  - last bit shifted or rotated out
//   co    - one-cycle count wrap pulse
module sdcrtt_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CONFLICT  = 0
) (
    input  logic             clk,
    input  logic             nr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             sout,
    output logic             co
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_TOGGLE = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_SHR    = 3'b100;
    localparam logic [2:0] MODE_ROL    = 3'b101;
    localparam logic [2:0] MODE_INC    = 3'b110;
    localparam logic [2:0] MODE_DEC    = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             co_nxt;

    // Mode result, shift-out bit and wrap flag; co reflects the arithmetic
    // wrap only, so set/clear overrides on the wrap cycle do not mask it.
    always_comb begin
        m        = q;
        sout_nxt = sout;
        co_nxt   = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD:   m = q;
                MODE_LOAD:   m = d;
                MODE_TOGGLE: m = q ^ d;
                MODE_SHL: begin
                    m        = {q[WIDTH-2:0], sin};
                    sout_nxt = q[WIDTH-1];
                end
                MODE_SHR: begin
                    m        = {sin, q[WIDTH-1:1]};
                    sout_nxt = q[0];
                end
                MODE_ROL: begin
                    m        = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_nxt = q[WIDTH-1];
                end
                MODE_INC: begin
                    m      = q + ONE;
                    co_nxt = &q;
                end
                MODE_DEC: begin
                    m      = q - ONE;
                    co_nxt = ~|q;
                end
                default: m = q;
            endcase
        end
    end

    // Per-bit overrides. Bits with exactly one of s/r asserted are forced;
    // bits with both asserted resolve according to CONFLICT (anything other
    // than 1 or 2 leaves the mode result in place).
    always_comb begin
        q_nxt = m;
        if (CONFLICT == 1) begin
            q_nxt = (m & ~r) | s;
        end else if (CONFLICT == 2) begin
            q_nxt = (m | s) & ~r;
        end else begin
            q_nxt = (m & ~(r & ~s)) | (s & ~r);
        end
    end

    always_ff @(posedge clk) begin
        if (!nr) begin
            q    <= RESET_VAL;
            nq   <= ~RESET_VAL;
            sout <= 1'b0;
            co   <= 1'b0;
        end else begin
            q    <= q_nxt;
            nq   <= ~q_nxt;
            sout <= sout_nxt;
            co   <= co_nxt;
        end
    end

endmodule

// File: tb/tb_sdcrtt_reg.sv
// tb/tb_sdcrtt_reg.sv - self-checking bench for sdcrtt_reg (three CONFLICT variants side by side)
module tb_sdcrtt_reg;

    localparam int          W   = 8;
    localparam logic [7:0]  RV  = 8'hA5;

    logic           clk = 1'b0;
    logic           nr;
    logic           en;
    logic [2:0]     mode;
    logic [W-1:0]   d, s, r;
    logic           sin;

    logic [2:0][W-1:0] qa, nqa;
    logic [2:0]        souta, coa;

    always #5 clk = ~clk;

    sdcrtt_reg #(.WIDTH(W), .RESET_VAL(RV), .CONFLICT(0)) u_dut0 (
        .clk(clk), .nr(nr), .en(en), .mode(mode), .d(d), .s(s), .r(r), .sin(sin),
        .q(qa[0]), .nq(nqa[0]), .sout(souta[0]), .co(coa[0])
    );
    sdcrtt_reg #(.WIDTH(W), .RESET_VAL(RV), .CONFLICT(1)) u_dut1 (
        .clk(clk), .nr(nr), .en(en), .mode(mode), .d(d), .s(s), .r(r), .sin(sin),
        .q(qa[1]), .nq(nqa[1]), .sout(souta[1]), .co(coa[1])
    );
    sdcrtt_reg #(.WIDTH(W), .RESET_VAL(RV), .CONFLICT(2)) u_dut2 (
        .clk(clk), .nr(nr), .en(en), .mode(mode), .d(d), .s(s), .r(r), .sin(sin),
        .q(qa[2]), .nq(nqa[2]), .sout(souta[2]), .co(coa[2])
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: instance k resolves s/r conflicts with policy k.
    logic [W-1:0] m_q    [3];
    logic         m_sout [3];
    logic         m_co   [3];
    logic         m_valid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!nr) begin
                m_q[k]    = RV;
                m_sout[k] = 1'b0;
                m_co[k]   = 1'b0;
            end else begin
                logic [W-1:0] res;
                res      = m_q[k];
                m_co[k]  = 1'b0;
                if (en) begin
                    case (mode)
                        3'd1: res = d;
                        3'd2: res = m_q[k] ^ d;
                        3'd3: begin res = (m_q[k] << 1) | W'(sin); m_sout[k] = m_q[k][W-1]; end
                        3'd4: begin res = (m_q[k] >> 1) | (W'(sin) << (W-1)); m_sout[k] = m_q[k][0]; end
                        3'd5: begin res = (m_q[k] << 1) | (m_q[k] >> (W-1)); m_sout[k] = m_q[k][W-1]; end
                        3'd6: begin res = m_q[k] + 1; m_co[k] = (int'(m_q[k]) == (1 << W) - 1); end
                        3'd7: begin res = m_q[k] - 1; m_co[k] = (m_q[k] == 0); end
                        default: res = m_q[k];
                    endcase
                end
                for (int i = 0; i < W; i++) begin
                    if (s[i] && !r[i])      res[i] = 1'b1;
                    else if (!s[i] && r[i]) res[i] = 1'b0;
                    else if (s[i] && r[i]) begin
                        if (k == 1)      res[i] = 1'b1;
                        else if (k == 2) res[i] = 1'b0;
                    end
                end
                m_q[k] = res;
            end
        end
        if (!nr) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_q[%0d]", k),    qa[k],            m_q[k]);
                chk($sformatf("model_nq[%0d]", k),   nqa[k],           ~m_q[k]);
                chk($sformatf("model_sout[%0d]", k), W'(souta[k]),     W'(m_sout[k]));
                chk($sformatf("model_co[%0d]", k),   W'(coa[k]),       W'(m_co[k]));
            end
        end
    end

    task automatic cyc(input logic n, input logic e, input logic [2:0] md,
                       input logic [W-1:0] dd, input logic [W-1:0] ss,
                       input logic [W-1:0] rr, input logic si);
        nr = n; en = e; mode = md; d = dd; s = ss; r = rr; sin = si;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        nr = 1'b0; en = 1'b0; mode = 3'd0; d = '0; s = '0; r = '0; sin = 1'b0;
        @(negedge clk);

        // Reset overrides a pending load
        cyc(0, 1, 3'd1, 8'hFF, 8'h00, 8'h00, 0);
        cyc(0, 1, 3'd1, 8'hFF, 8'h00, 8'h00, 0);
        chk("rst_q",    qa[2],         8'hA5);
        chk("rst_nq",   nqa[2],        8'h5A);
        chk("rst_sout", W'(souta[2]),  8'h00);
        chk("rst_co",   W'(coa[2]),    8'h00);
        cyc(1, 1, 3'd1, 8'h3C, 8'h00, 8'h00, 0);
        chk("load_q",  qa[2],  8'h3C);
        chk("load_nq", nqa[2], 8'hC3);

        // Shift / rotate
        cyc(1, 1, 3'd1, 8'h81, 8'h00, 8'h00, 0);
        cyc(1, 1, 3'd3, 8'h00, 8'h00, 8'h00, 0);
        chk("shl_q", qa[2], 8'h02);
        chk("shl_sout", W'(souta[2]), 8'h01);
        cyc(1, 1, 3'd4, 8'h00, 8'h00, 8'h00, 1);
        chk("shr_q", qa[2], 8'h81);
        chk("shr_sout", W'(souta[2]), 8'h00);
        cyc(1, 1, 3'd5, 8'h00, 8'h00, 8'h00, 0);
        chk("rol_q", qa[2], 8'h03);
        chk("rol_sout", W'(souta[2]), 8'h01);

        // Counter wrap up and down
        cyc(1, 1, 3'd1, 8'hFE, 8'h00, 8'h00, 0);
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("inc1_q", qa[2], 8'hFF); chk("inc1_co", W'(coa[2]), 8'h00);
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("inc2_q", qa[2], 8'h00); chk("inc2_co", W'(coa[2]), 8'h01);
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("inc3_q", qa[2], 8'h01); chk("inc3_co", W'(coa[2]), 8'h00);
        cyc(1, 1, 3'd1, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 1, 3'd7, 8'h00, 8'h00, 8'h00, 0);
        chk("dec_q", qa[2], 8'hFF); chk("dec_co", W'(coa[2]), 8'h01);
        cyc(1, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("dec_co_drop", W'(coa[2]), 8'h00);

        // Wrap with a forced bit still raises co
        cyc(1, 1, 3'd6, 8'h00, 8'h01, 8'h00, 0);
        chk("wrap_ovr_q", qa[2], 8'h01); chk("wrap_ovr_co", W'(coa[2]), 8'h01);

        // Overrides with en=0, then conflict policies
        cyc(1, 1, 3'd1, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 0, 3'd0, 8'h00, 8'h0F, 8'h00, 0);
        chk("ovr_en0_q", qa[0], 8'h0F);
        cyc(1, 1, 3'd1, 8'h00, 8'hFF, 8'hF0, 0);
        chk("conf0_q", qa[0], 8'h0F);
        chk("conf1_q", qa[1], 8'hFF);
        chk("conf2_q", qa[2], 8'h0F);

        // Toggle, then enable low holds everything
        cyc(1, 1, 3'd1, 8'h55, 8'h00, 8'h00, 0);
        cyc(1, 1, 3'd2, 8'hFF, 8'h00, 8'h00, 0);
        chk("tog_q", qa[2], 8'hAA);
        repeat (3) cyc(1, 0, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("en0_q", qa[2], 8'hAA);
        chk("en0_co", W'(coa[2]), 8'h00);
        chk("en0_sout", W'(souta[2]), 8'h01);

        // Reset mid-count, coincident with set-all
        cyc(1, 1, 3'd1, 8'h10, 8'h00, 8'h00, 0);
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("cnt_q", qa[2], 8'h11);
        cyc(0, 1, 3'd6, 8'h00, 8'hFF, 8'h00, 0);
        chk("mid_rst_q",  qa[2],  8'hA5);
        chk("mid_rst_nq", nqa[2], 8'h5A);
        chk("mid_rst_co", W'(coa[2]), 8'h00);
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("resume1_q", qa[2], 8'hA6);
        cyc(1, 1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("resume2_q", qa[2], 8'hA7);

        // Mixed vectors against the model only
        for (int n = 0; n < 60; n++) begin
            cyc(($urandom_range(0, 15) != 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom & $urandom), 8'($urandom & $urandom), $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
